mem_bus_sequencer: RTL and testbench

Parametrised memory-access sequencer between the CPU control unit and the external memory/bus. Turns single-cycle read/write requests from the controller into multi-T-state bus transactions with programmable wait M-cycles, a memory-ready stall and optional address post-increment/decrement. Targets HL+/HL-/PC-style sequential accesses. Replaces ad-hoc `mem_cs`/`mem_oe` driving with a handshaked, width-generic unit.

---
 rtl/mem_bus_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sequencer.sv
// Memory/bus access sequencer: turns one-cycle controller requests into multi-T-state bus
// transactions with programmable wait M-cycles, ready stall and address post-step.
`timescale 1ns / 1ps
module mem_bus_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned T_PER_M = 4,
  parameter int unsigned WAIT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAIT_W-1:0] req_wait,
  input  logic [1:0]        req_step,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr_next,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_dout_en,
  input  logic [DATA_W-1:0] mem_din,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic              mem_rdy,
  output logic              busy
);

  // T_PER_M <= 16 fits in 5 bits, so wait*T_PER_M always fits in WAIT_W+5 bits.
  localparam int unsigned CntW = WAIT_W + 5;

  typedef enum logic [2:0] {StIdle, StT1, StAct, StWait, StLast} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_next_q, addr_next_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              last_done, accept, data_phase;
  logic [CntW-1:0]   wait_clks;
  logic [ADDR_W-1:0] addr_stepped;

  assign last_done = (state_q == StLast) && mem_rdy;
  assign req_ready = (state_q == StIdle) || last_done;
  assign accept    = req_valid && req_ready;
  assign wait_clks = CntW'(wait_q) * CntW'(T_PER_M) - CntW'(1);

  always_comb begin
    unique case (step_q)
      2'b01:   addr_stepped = addr_q + ADDR_W'(1);
      2'b10:   addr_stepped = addr_q - ADDR_W'(1);
      default: addr_stepped = addr_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    wait_d      = wait_q;
    step_d      = step_q;
    addr_d      = addr_q;
    addr_next_d = addr_next_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StT1;
      end
      StT1: begin
        if (T_PER_M > 2) begin
          state_d = StAct;
          cnt_d   = CntW'(T_PER_M) - CntW'(3);
        end else if (wait_q != '0) begin
          state_d = StWait;
          cnt_d   = wait_clks;
        end else begin
          state_d = StLast;
        end
      end
      StAct: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (wait_q != '0) begin
          state_d = StWait;
          cnt_d   = wait_clks;
        end else begin
          state_d = StLast;
        end
      end
      StWait: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        else             state_d = StLast;
      end
      StLast: begin
        if (mem_rdy) begin
          rsp_valid_d = 1'b1;
          addr_next_d = addr_stepped;
          if (!we_q) rdata_d = mem_din;
          state_d = accept ? StT1 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Request fields are captured only on the accept edge.
    if (accept) begin
      we_d   = req_we;
      addr_d = req_addr;
      wait_d = req_wait;
      step_d = req_step;
      if (req_we) dout_d = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      step_q      <= '0;
      addr_q      <= '0;
      addr_next_q <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      step_q      <= step_d;
      addr_q      <= addr_d;
      addr_next_q <= addr_next_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Strobes decode from state registers only, so reset drops them asynchronously.
  assign data_phase    = (state_q == StAct) || (state_q == StWait) || (state_q == StLast);
  assign busy          = (state_q != StIdle);
  assign mem_cs        = busy;
  assign mem_oe        = data_phase && !we_q;
  assign mem_we        = data_phase && we_q;
  assign mem_dout_en   = data_phase && we_q;
  assign mem_addr      = addr_q;
  assign mem_dout      = dout_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_addr_next = addr_next_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench for mem_bus_sequencer: per-scenario tasks plus a response scoreboard.
`timescale 1ns / 1ps
module tb_mem_bus_sequencer;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [1:0]  req_wait, req_step;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] rsp_addr_next, mem_addr;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_dout_en, mem_cs, mem_oe, mem_we, mem_rdy, busy;

  mem_bus_sequencer #(
    .DATA_W (8),
    .ADDR_W (16),
    .T_PER_M(4),
    .WAIT_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wait     (req_wait),
    .req_step     (req_step),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_addr_next(rsp_addr_next),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .mem_dout_en  (mem_dout_en),
    .mem_din      (mem_din),
    .mem_cs       (mem_cs),
    .mem_oe       (mem_oe),
    .mem_we       (mem_we),
    .mem_rdy      (mem_rdy),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] next;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       sb_e;
  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] model_rdata = 8'h00;

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=1 addr_next=%h, required no response",
                 rsp_addr_next);
      end else begin
        sb_e = exp_q.pop_front();
        if (rsp_rdata !== sb_e.rdata || rsp_addr_next !== sb_e.next) begin
          errors++;
          $display("FAIL rsp_data: rdata=%h addr_next=%h, required rdata=%h addr_next=%h",
                   rsp_rdata, rsp_addr_next, sb_e.rdata, sb_e.next);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] step_addr(input logic [15:0] a, input logic [1:0] s);
    case (s)
      2'b01:   return a + 16'd1;
      2'b10:   return a - 16'd1;
      default: return a;
    endcase
  endfunction

  // Drives one request from IDLE and profiles the transaction until its response pulse.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [1:0] wt, input logic [1:0] step, input int stall,
                         input logic [7:0] din_base, input bit din_vary,
                         output int cs_n, output int oe_n, output int wr_n,
                         output int rsp_cyc, output bit t1_ok, output bit addr_ok);
    int   nominal;
    exp_t e;
    nominal = 4 * (1 + int'(wt));
    e.next  = step_addr(addr, step);
    e.rdata = we ? model_rdata : (din_vary ? 8'(int'(din_base) + nominal + stall) : din_base);
    model_rdata = e.rdata;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_wait = wt; req_step = step; mem_rdy = 1'b1; mem_din = din_base;
    cs_n = 0; oe_n = 0; wr_n = 0; rsp_cyc = -1; t1_ok = 1'b0; addr_ok = 1'b1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: req_ready=%b, required 1", req_ready);
    end
    exp_q.push_back(e);
    tick();
    // Scramble request inputs mid-transaction; they must be ignored.
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    req_wait = ~wt; req_step = ~step;
    for (int c = 1; c <= 80; c++) begin
      mem_rdy = (c >= nominal + stall);
      mem_din = din_vary ? 8'(int'(din_base) + c) : din_base;
      if (rsp_valid) begin
        rsp_cyc = c;
        break;
      end
      if (c == 1) t1_ok = mem_cs && !mem_oe && !mem_we && !mem_dout_en;
      if (mem_cs) begin
        cs_n++;
        if (mem_addr !== addr) addr_ok = 1'b0;
      end
      if (mem_oe) oe_n++;
      if (mem_we && mem_dout_en && mem_dout === wdata) wr_n++;
      tick();
    end
    mem_rdy = 1'b1;
    vectors++;
    if (rsp_cyc < 0) begin
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid within 80 clks, required one");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wait = '0; req_step = '0; mem_din = '0; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, busy, mem_cs, mem_oe, mem_we, mem_dout_en} !== 7'b1000000 ||
        mem_addr !== 16'h0 || mem_dout !== 8'h0 || rsp_rdata !== 8'h0 ||
        rsp_addr_next !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: rdy/val/busy/cs/oe/we/en=%b addr=%h dout=%h rd=%h nxt=%h, %s",
               {req_ready, rsp_valid, busy, mem_cs, mem_oe, mem_we, mem_dout_en}, mem_addr,
               mem_dout, rsp_rdata, rsp_addr_next, "required 1000000 and zeros");
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_read();
    int cs_n, oe_n, wr_n, rsp_cyc;
    bit t1_ok, addr_ok;
    run_txn(1'b0, 16'hC000, 8'h00, 2'd0, 2'b00, 0, 8'h5A, 1'b0,
            cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok);
    vectors++;
    if (cs_n != 4 || oe_n != 3 || wr_n != 0 || rsp_cyc != 5 || !t1_ok || !addr_ok) begin
      errors++;
      $display("FAIL read_timing: cs=%0d oe=%0d we=%0d rsp@%0d t1=%0b addr=%0b, %s",
               cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok, "required 4 3 0 rsp@5 1 1");
    end
    vectors++;
    if (rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_data: rsp_rdata=%h, required 5a", rsp_rdata);
    end
  endtask

  task automatic test_write();
    int cs_n, oe_n, wr_n, rsp_cyc;
    bit t1_ok, addr_ok;
    run_txn(1'b1, 16'hFF80, 8'h3C, 2'd2, 2'b00, 0, 8'hC3, 1'b0,
            cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok);
    vectors++;
    if (cs_n != 12 || oe_n != 0 || wr_n != 11 || rsp_cyc != 13 || !t1_ok || !addr_ok) begin
      errors++;
      $display("FAIL write_timing: cs=%0d oe=%0d we=%0d rsp@%0d t1=%0b addr=%0b, %s",
               cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok, "required 12 0 11 rsp@13 1 1");
    end
    vectors++;
    if (rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL write_rdata_hold: rsp_rdata=%h, required 5a", rsp_rdata);
    end
  endtask

  task automatic test_stall();
    int cs_n, oe_n, wr_n, rsp_cyc;
    bit t1_ok, addr_ok;
    run_txn(1'b0, 16'h1230, 8'h00, 2'd0, 2'b01, 3, 8'h40, 1'b1,
            cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok);
    vectors++;
    if (cs_n != 7 || oe_n != 6 || rsp_cyc != 8 || !t1_ok || !addr_ok) begin
      errors++;
      $display("FAIL stall_timing: cs=%0d oe=%0d rsp@%0d t1=%0b addr=%0b, %s",
               cs_n, oe_n, rsp_cyc, t1_ok, addr_ok, "required 7 6 rsp@8 1 1");
    end
    vectors++;
    if (rsp_rdata !== 8'h47 || rsp_addr_next !== 16'h1231) begin
      errors++;
      $display("FAIL stall_data: rdata=%h next=%h, required 47 1231", rsp_rdata, rsp_addr_next);
    end
  endtask

  task automatic test_back_to_back();
    int   acc[$];
    exp_t e;
    req_valid = 1'b1; req_we = 1'b0; req_step = 2'b01; req_wait = 2'd0;
    req_addr = 16'h4000; mem_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      mem_din = 8'(8'h20 + c);
      if (c == 5) begin
        vectors++;
        if (!(mem_cs && rsp_valid && !mem_oe && mem_addr === 16'h4010)) begin
          errors++;
          $display("FAIL b2b_overlap: cs=%b rsp_valid=%b oe=%b addr=%h, required 1 1 0 4010",
                   mem_cs, rsp_valid, mem_oe, mem_addr);
        end
      end
      if (req_valid && req_ready) begin
        e.rdata = 8'(8'h20 + c + 4);
        e.next  = req_addr + 16'd1;
        model_rdata = e.rdata;
        exp_q.push_back(e);
        acc.push_back(c);
      end
      tick();
      if (acc.size() >= 3) req_valid = 1'b0;
      req_addr = 16'h4000 + 16'(acc.size() * 16);
    end
    vectors++;
    if (acc.size() != 3) begin
      errors++;
      $display("FAIL b2b_accepts: %0d accepts, required 3", acc.size());
    end else if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
      errors++;
      $display("FAIL b2b_accepts: accepts at %0d %0d %0d, required 0 4 8", acc[0], acc[1], acc[2]);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d responses missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_step_wrap();
    int cs_n, oe_n, wr_n, rsp_cyc;
    bit t1_ok, addr_ok;
    logic [15:0] addrs[3] = '{16'hFFFF, 16'h0000, 16'h1234};
    logic [1:0]  steps[3] = '{2'b01, 2'b10, 2'b11};
    logic [15:0] wants[3] = '{16'h0000, 16'hFFFF, 16'h1234};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, addrs[i], 8'h00, 2'd0, steps[i], 0, 8'(8'h90 + i), 1'b0,
              cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok);
      vectors++;
      if (rsp_addr_next !== wants[i]) begin
        errors++;
        $display("FAIL step_wrap: addr=%h step=%b next=%h, required %h",
                 addrs[i], steps[i], rsp_addr_next, wants[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int cs_n, oe_n, wr_n, rsp_cyc;
    bit t1_ok, addr_ok;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h2222; req_wdata = 8'h99;
    req_wait = 2'd0; req_step = 2'b01; mem_rdy = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if (!(mem_we && mem_cs)) begin
      errors++;
      $display("FAIL abort_pre: mem_we=%b mem_cs=%b in TACT, required 1 1", mem_we, mem_cs);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_we, mem_cs, mem_oe, mem_dout_en, busy} !== 5'b0) begin
      errors++;
      $display("FAIL abort_async: we/cs/oe/en/busy=%b before next edge, required 00000",
               {mem_we, mem_cs, mem_oe, mem_dout_en, busy});
    end
    model_rdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: req_ready=%b busy=%b rsp_valid=%b, required 1 0 0",
               req_ready, busy, rsp_valid);
    end
    repeat (8) tick();
    run_txn(1'b0, 16'h0ABC, 8'h00, 2'd0, 2'b00, 0, 8'hE7, 1'b0,
            cs_n, oe_n, wr_n, rsp_cyc, t1_ok, addr_ok);
    vectors++;
    if (rsp_cyc != 5 || cs_n != 4 || rsp_rdata !== 8'hE7) begin
      errors++;
      $display("FAIL abort_fresh_read: rsp@%0d cs=%0d rdata=%h, required rsp@5 4 e7",
               rsp_cyc, cs_n, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_back_to_back();
    test_step_wrap();
    test_reset_abort();
    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
